seq_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider; the responder side of the execute stage's divide handshake (sourceData / hasData / dataOK).
- Accepts signed or unsigned 32-bit operands and returns {quotient, remainder} for HI/LO writeback.
- Drives the busy/finish indication the execute stage uses to stall the pipeline.
- Sits beside the ALU inside execute; purely datapath, no CP0 interaction.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
// Holds the FSM encoding, the default widths and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // shifted < 2*divisor, so a successful trial always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem, msb};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider for the execute stage.
// Fixed latency: accept, WIDTH iterations, then a one-cycle dataOK pulse.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               int_flush,
    input  logic               sign,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sourceData,
    output logic [2*WIDTH-1:0] F,
    output logic               hasData,
    output logic               dataOK
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             qneg;
    logic             rneg;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quot_raw;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .msb      (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (sourceData) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (int_flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            last       = 1'b0;
        end
    end

    always_comb begin
        a_abs    = (sign & A[WIDTH-1]) ? -A : A;
        b_abs    = (sign & B[WIDTH-1]) ? -B : B;
        quot_raw = {dvd[WIDTH-2:0], q_bit};
        quot_fin = qneg ? -quot_raw : quot_raw;
        rem_fin  = rneg ? -rem_next : rem_next;
        // With a zero divisor every trial succeeds, so the remainder already
        // reconstructs A; only the quotient needs the override.
        if (dsr == '0) begin
            quot_fin = DIV0_QUOT[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            F     <= '0;
        end else begin
            state <= state_next;
            if (int_flush) begin
                cnt <= '0;
            end else if (accept) begin
                cnt  <= '0;
                rem  <= '0;
                dvd  <= a_abs;
                dsr  <= b_abs;
                qneg <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                rneg <= sign & A[WIDTH-1];
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
                rem <= rem_next;
                dvd <= quot_raw;
                if (last) begin
                    F <= {quot_fin, rem_fin};
                end
            end
        end
    end

    // hasData rises in the request cycle itself so the pipeline stalls at once.
    assign hasData = ~int_flush & ((state != IDLE) | sourceData);
    assign dataOK  = ~int_flush & (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, sign handling,
// divide-by-zero, flush, back-to-back and mid-operation reset.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        int_flush;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        sourceData;
    logic [63:0] F;
    logic        hasData;
    logic        dataOK;

    int checks;
    int errors;

    seq_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_flush  (int_flush),
        .sign       (sign),
        .A          (A),
        .B          (B),
        .sourceData (sourceData),
        .F          (F),
        .hasData    (hasData),
        .dataOK     (dataOK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Accepts one operation in the current cycle (cycle 0) and waits for dataOK.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int done_c, output logic [63:0] f,
                          output logic has0, output logic tail_ok);
        @(negedge clk);
        sign = s; A = a; B = b; sourceData = 1'b1;
        #1 has0 = hasData;
        done_c  = -1;
        f       = '0;
        tail_ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                A = $urandom; B = $urandom; sign = 1'($urandom_range(0, 1));
            end
            #1;
            if (dataOK) begin
                if (done_c < 0) begin
                    done_c = c;
                    f = F;
                end
                sourceData = 1'b0;
            end else if (done_c >= 0 && c == done_c + 1) begin
                tail_ok = !hasData;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; int_flush = 1'b0; sourceData = 1'b0;
        sign = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (F !== 64'd0) begin errors++; $display("FAIL reset_f: got %h expected 0", F); end
        checks++;
        if (hasData !== 1'b0) begin errors++; $display("FAIL reset_hasdata: got %b expected 0", hasData); end
        checks++;
        if (dataOK !== 1'b0) begin errors++; $display("FAIL reset_dataok: got %b expected 0", dataOK); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        int done_c; logic [63:0] f; logic has0, tail_ok;
        run_op(1'b0, 32'd100, 32'd7, done_c, f, has0, tail_ok);
        checks++;
        if (has0 !== 1'b1) begin errors++; $display("FAIL unsigned_hasdata0: got %b expected 1", has0); end
        checks++;
        if (done_c != 33) begin errors++; $display("FAIL unsigned_latency: got %0d expected 33", done_c); end
        checks++;
        if (f !== {32'd14, 32'd2}) begin errors++; $display("FAIL unsigned_f: got %h expected %h", f, {32'd14, 32'd2}); end
        checks++;
        if (tail_ok !== 1'b1) begin errors++; $display("FAIL unsigned_tail: got %b expected 1", tail_ok); end
        checks++;
        if (F !== {32'd14, 32'd2}) begin errors++; $display("FAIL unsigned_hold: got %h expected %h", F, {32'd14, 32'd2}); end
    endtask

    task automatic test_signed;
        int done_c; logic [63:0] f; logic has0, tail_ok;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, done_c, f, has0, tail_ok);
        checks++;
        if (done_c != 33) begin errors++; $display("FAIL signed_nn_latency: got %0d expected 33", done_c); end
        checks++;
        if (f !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin errors++; $display("FAIL signed_neg_dividend: got %h expected fffffffdffffffff", f); end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, done_c, f, has0, tail_ok);
        checks++;
        if (f !== {32'hFFFF_FFFD, 32'h0000_0001}) begin errors++; $display("FAIL signed_neg_divisor: got %h expected fffffffd00000001", f); end
        checks++;
        if (tail_ok !== 1'b1) begin errors++; $display("FAIL signed_tail: got %b expected 1", tail_ok); end
    endtask

    task automatic test_overflow;
        int done_c; logic [63:0] f; logic has0, tail_ok;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, done_c, f, has0, tail_ok);
        checks++;
        if (f !== {32'h8000_0000, 32'h0}) begin errors++; $display("FAIL overflow_f: got %h expected 8000000000000000", f); end
    endtask

    task automatic test_div_zero;
        int done_c; logic [63:0] f; logic has0, tail_ok;
        run_op(1'b0, 32'h1234_5678, 32'd0, done_c, f, has0, tail_ok);
        checks++;
        if (done_c != 33) begin errors++; $display("FAIL div0_latency: got %0d expected 33", done_c); end
        checks++;
        if (f !== {32'hFFFF_FFFF, 32'h1234_5678}) begin errors++; $display("FAIL div0_unsigned: got %h expected ffffffff12345678", f); end
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, done_c, f, has0, tail_ok);
        checks++;
        if (f !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin errors++; $display("FAIL div0_signed: got %h expected fffffffffffffffb", f); end
    endtask

    // Previous result on entry is the signed divide-by-zero value.
    task automatic test_flush;
        int seen; int done_c;
        seen = 0; done_c = -1;
        @(negedge clk);
        sign = 1'b0; A = 32'd100; B = 32'd7; sourceData = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 10) begin int_flush = 1'b1; sourceData = 1'b0; end
            if (c == 11) int_flush = 1'b0;
            #1;
            if (dataOK) seen++;
            if (c == 10) begin
                checks++;
                if (hasData !== 1'b0) begin errors++; $display("FAIL flush_hasdata: got %b expected 0", hasData); end
            end
            if (c == 11) begin
                checks++;
                if (F !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin errors++; $display("FAIL flush_f_kept: got %h expected fffffffffffffffb", F); end
                checks++;
                if (hasData !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b expected 0", hasData); end
            end
        end
        @(negedge clk);
        sign = 1'b0; A = 32'd9; B = 32'd3; sourceData = 1'b1;
        for (int c = 13; c <= 70; c++) begin
            @(negedge clk);
            #1;
            if (dataOK) begin
                done_c = c;
                sourceData = 1'b0;
                break;
            end
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_dataok: got %0d pulses expected 0", seen); end
        checks++;
        if (done_c != 45) begin errors++; $display("FAIL flush_relaunch_latency: got %0d expected 45", done_c); end
        checks++;
        if (F !== {32'd3, 32'd0}) begin errors++; $display("FAIL flush_relaunch_f: got %h expected %h", F, {32'd3, 32'd0}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int d1, d2, pulses;
        logic [63:0] f1, f2;
        logic has_next;
        d1 = -1; d2 = -1; pulses = 0; f1 = '0; f2 = '0; has_next = 1'b0;
        @(negedge clk);
        sign = 1'b0; A = 32'd1000; B = 32'd10; sourceData = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            #1;
            if (d1 >= 0 && c == d1 + 1) has_next = hasData;
            if (dataOK) begin
                pulses++;
                if (d1 < 0) begin
                    d1 = c; f1 = F; A = 32'd50; B = 32'd5;
                end else begin
                    d2 = c; f2 = F; sourceData = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (d1 != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", d1); end
        checks++;
        if (f1 !== {32'd100, 32'd0}) begin errors++; $display("FAIL b2b_first_f: got %h expected %h", f1, {32'd100, 32'd0}); end
        checks++;
        if (has_next !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", has_next); end
        checks++;
        if (d2 - d1 != 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", d2 - d1); end
        checks++;
        if (f2 !== {32'd10, 32'd0}) begin errors++; $display("FAIL b2b_second_f: got %h expected %h", f2, {32'd10, 32'd0}); end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int seen;
        seen = 0;
        @(negedge clk);
        sign = 1'b0; A = 32'd100; B = 32'd7; sourceData = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 5) begin rst_n = 1'b0; sourceData = 1'b0; end
            if (c == 6) rst_n = 1'b1;
            #1;
            if (dataOK) seen++;
            if (c == 6) begin
                checks++;
                if (F !== 64'd0) begin errors++; $display("FAIL rstmid_f: got %h expected 0", F); end
                checks++;
                if (hasData !== 1'b0) begin errors++; $display("FAIL rstmid_hasdata: got %b expected 0", hasData); end
            end
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_dataok: got %0d pulses expected 0", seen); end
        checks++;
        if (F !== 64'd0) begin errors++; $display("FAIL rstmid_f_end: got %h expected 0", F); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
